imem_dmem_arbiter: RTL and testbench
====================================

# imem_dmem_arbiter

Arbitrates a single-ported memory between the instruction fetch stage and the load/store (data) stage of the pipelined core. It accepts one request per cycle from either requester and drives a held-until-ready memory transaction. Results return to the winner through a one-cycle valid pulse. Data accesses have priority, and an optional starvation guard bounds how long fetch can be locked out.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (guard build only, ≥1)

Ports:
- stage_clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- f_req  in  1  fetch request (read)
- f_addr  in  ADDR_W  fetch address
- f_gnt  out  1  fetch request accepted (1-cycle pulse)
- f_valid  out  1  fetch data returned (1-cycle pulse)
- f_rdata  out  DATA_W  fetched instruction word
- d_req  in  1  data request
- d_we  in  1  data write enable
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_be  in  DATA_W/8  byte enables
- d_gnt  out  1  data request accepted (1-cycle pulse)
- d_valid  out  1  data access complete (1-cycle pulse)
- d_rdata  out  DATA_W  load data
- mem_req  out  1  memory transaction active
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
- mem_ready  in  1  transaction complete this cycle
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, BUSY_F, BUSY_D.
- **Arbitration point:**
  - Occurs in IDLE, and in BUSY_x on the cycle mem_ready=1.
  - Winner: d_req if asserted, else f_req. In the guard build the winner is fetch instead when starvation is flagged.
- **On a win at a clock edge:**
  - Latch address/we/wdata/be into the memory registers.
  - Pulse the matching gnt.
  - Enter BUSY_D or BUSY_F. mem_req stays registered high.
- **Fetch transactions:** mem_we=0, mem_be=all ones.
- **In BUSY_x:** mem_addr/mem_we/mem_wdata/mem_be remain stable until mem_ready=1.
- **At the edge where mem_ready=1:**
  - Pulse x_valid.
  - For fetch and data reads, capture mem_rdata into f_rdata or d_rdata. Writes leave d_rdata unchanged.
  - Re-arbitrate. With no request pending, go to IDLE and drop mem_req (registered).
- **Requester rules:**
  - Hold req and its operands stable until gnt is seen.
  - req still high in the gnt cycle counts as a new request.
- Neither requester ever has more than one transaction outstanding. A new request from a requester is accepted only at the next arbitration point.
- mem_ready outside BUSY_x is ignored.

## Timing
- **Reset values (asynchronous reset):**
  - All outputs 0 and state IDLE.
  - mem_req drops immediately.
  - Any in-flight transaction is abandoned with no valid pulse.
- **Request accepted at edge E:**
  - gnt=1 and mem_req=1 during E..E+1.
  - With zero-wait memory (mem_ready=1 in that cycle), valid and rdata appear in cycle E+1..E+2.
  - Latency: req sampled → valid is 2 edges, plus one edge per wait state.
- **Back-to-back:**
  - mem_req is continuous across consecutive transactions.
  - Zero-wait throughput is one access per cycle.
  - The valid of transaction n and the gnt of transaction n+1 appear in the same cycle.
- **Simultaneous f_req and d_req:** data is granted first and fetch at the next arbitration point, unless the starvation guard fires.

## Configuration
Macro: MEM_ARB_STARVE_GUARD_EN.
- **Defined:**
  - A counter of width $clog2(STARVE_LIMIT+1) increments on each data grant made while f_req=1.
  - It clears on a fetch grant or when f_req=0 at an arbitration point.
  - When it equals STARVE_LIMIT, the next arbitration grants fetch even if d_req=1.
  - The counter saturates and resets to 0.
- **Undefined:** strict data priority. No counter exists, and fetch can starve indefinitely.

## Test plan
- **Single fetch, zero-wait:** f_req=1, f_addr=0x4, mem_ready=1, mem_rdata=0x00500093 → f_gnt and mem_req with mem_addr=0x4 one edge later; f_valid=1 with f_rdata=0x00500093 on the next edge; mem_req=0 after.
- **Simultaneous requests:** f_req=d_req=1 (d_addr=0x100, read) → d_gnt first, then f_gnt on the edge of d_valid; mem_req stays high across both.
- **Wait states:** d write to 0x200, wdata=0xDEADBEEF, be=0b0011, mem_ready low 3 cycles → mem_addr/mem_wdata/mem_be stable for 4 cycles; d_valid one edge after mem_ready; d_rdata unchanged.
- **Starvation, guard build:** d_req and f_req held high, STARVE_LIMIT=4 → pattern of 4 d_gnt then 1 f_gnt, repeating.
- **Starvation, no-guard build:** same stimulus → zero f_gnt over 50 cycles.
- **Reset mid-transaction:** assert reset during BUSY_F with mem_ready=0 → mem_req, busy and all pulses go to 0 immediately, with no f_valid; after release, a fresh f_req to 0x8 completes normally.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-ported memory between instruction
// fetch and the load/store stage. Data has priority. Each access is held on
// the memory port until mem_ready. Grants and completions are one-cycle
// pulses back to the requester.
// Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN. Fetch is then
// forced through after STARVE_LIMIT consecutive data grants made while it
// was waiting.
//
// Handshake: a requester holds x_req and its operands stable until it sees
// x_gnt. Requests are sampled only at arbitration points, which are IDLE, or
// a BUSY cycle with mem_ready=1. If x_req is still high during the x_gnt
// cycle, it counts as a new request. On the memory side, mem_req and the
// operands stay stable until the cycle in which mem_ready=1 completes the
// access.
module imem_dmem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                stage_clk,
   input  logic                reset,
   input  logic                f_req,
   input  logic [ADDR_W-1:0]   f_addr,
   output logic                f_gnt,
   output logic                f_valid,
   output logic [DATA_W-1:0]   f_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_gnt,
   output logic                d_valid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ready,
   output logic                busy,
   output logic [1:0]          state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_F = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   arb, win_f, win_d, starve;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;

   assign starve = (starve_cnt == CNT_W'(STARVE_LIMIT));

   // Count data grants that pass over a waiting fetch.
   // Clear the count when fetch wins or is not asking.
   always_comb begin
      starve_cnt_nxt = starve_cnt;
      if (arb) begin
         if (win_f || !f_req)
            starve_cnt_nxt = '0;
         else if (win_d && !starve)
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
      end
   end

   // Starvation counter register
   always_ff @(posedge stage_clk or posedge reset) begin
      if (reset) starve_cnt <= '0;
      else       starve_cnt <= starve_cnt_nxt;
   end
`else
   // STARVE_LIMIT is always >= 1, so fetch is never promoted.
   // This gives strict data priority.
   assign starve = (STARVE_LIMIT == 0);
`endif

   // Arbitration and next state.
   // Arbitration happens when idle or when the current access completes.
   always_comb begin
      arb       = (state == IDLE) || mem_ready;
      win_f     = arb && f_req && (!d_req || starve);
      win_d     = arb && d_req && !win_f;
      state_nxt = state;
      if (arb) begin
         if (win_d)      state_nxt = BUSY_D;
         else if (win_f) state_nxt = BUSY_F;
         else            state_nxt = IDLE;
      end
   end

   // State register
   always_ff @(posedge stage_clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Registered pulses, memory port and returned read data
   always_ff @(posedge stage_clk or posedge reset) begin
      if (reset) begin
         f_gnt     <= 1'b0;
         d_gnt     <= 1'b0;
         f_valid   <= 1'b0;
         d_valid   <= 1'b0;
         f_rdata   <= '0;
         d_rdata   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
      end else begin
         f_gnt   <= win_f;
         d_gnt   <= win_d;
         f_valid <= (state == BUSY_F) && mem_ready;
         d_valid <= (state == BUSY_D) && mem_ready;
         if ((state == BUSY_F) && mem_ready)
            f_rdata <= mem_rdata;
         // Writes complete without touching the load data.
         if ((state == BUSY_D) && mem_ready && !mem_we)
            d_rdata <= mem_rdata;
         if (arb)
            mem_req <= win_f || win_d;
         if (win_d) begin
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
         end else if (win_f) begin
            mem_we    <= 1'b0;
            mem_addr  <= f_addr;
            mem_wdata <= '0;
            mem_be    <= '1;
         end
      end
   end

   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Testbench for imem_dmem_arbiter.
// The bench runs these phases in order:
//   - reset check;
//   - table of single-step vectors (single fetch, simultaneous requests,
//     write with wait states);
//   - starvation sequence;
//   - reset during a fetch;
//   - randomized traffic checked against a transaction-level model.
module tb_imem_dmem_arbiter;

   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 32;
   localparam int BE_W         = DATA_W / 8;
   localparam int STARVE_LIMIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic              stage_clk = 1'b0;
   logic              reset;
   logic              f_req, f_gnt, f_valid;
   logic [ADDR_W-1:0] f_addr;
   logic [DATA_W-1:0] f_rdata;
   logic              d_req, d_we, d_gnt, d_valid;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata, d_rdata;
   logic [BE_W-1:0]   d_be;
   logic              mem_req, mem_we, mem_ready, busy;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic [BE_W-1:0]   mem_be;
   logic [1:0]        state_dbg;

   always #5 stage_clk = ~stage_clk;

   imem_dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .stage_clk(stage_clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .busy(busy), .state_dbg(state_dbg)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   // The model tracks who owns the memory, plus a copy of the latched
   // operands. It also counts how many data grants have passed over a
   // waiting fetch.
   int              m_owner;   // 0 none, 1 fetch, 2 data
   int              m_waits;
   logic            m_f_gnt, m_d_gnt, m_f_valid, m_d_valid;
   logic            m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata, m_f_rdata, m_d_rdata;
   logic [BE_W-1:0]   m_be;

   task automatic model_reset();
      m_owner = 0; m_waits = 0;
      m_f_gnt = 0; m_d_gnt = 0; m_f_valid = 0; m_d_valid = 0;
      m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
      m_f_rdata = '0; m_d_rdata = '0;
   endtask

   // Called right after a rising edge, using the inputs present at that edge.
   task automatic model_step();
      bit decide, give_f, give_d;
      decide = (m_owner == 0) || mem_ready;
      m_f_gnt = 0; m_d_gnt = 0; m_f_valid = 0; m_d_valid = 0;
      if (m_owner == 1 && mem_ready) begin
         m_f_valid = 1; m_f_rdata = mem_rdata;
      end
      if (m_owner == 2 && mem_ready) begin
         m_d_valid = 1;
         if (!m_we) m_d_rdata = mem_rdata;
      end
      if (decide) begin
         give_f = f_req && (!d_req || (GUARD && m_waits >= STARVE_LIMIT));
         give_d = d_req && !give_f;
         if (give_d) begin
            m_owner = 2; m_d_gnt = 1;
            m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
            m_waits = f_req ? m_waits + 1 : 0;
         end else if (give_f) begin
            m_owner = 1; m_f_gnt = 1;
            m_we = 0; m_addr = f_addr; m_be = '1;
            m_waits = 0;
         end else begin
            m_owner = 0; m_waits = 0;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      f_req = 0; f_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
      mem_ready = 0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      @(negedge stage_clk);
      @(negedge stage_clk);
      reset = 0;
      model_reset();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic              f_req;
      logic [ADDR_W-1:0] f_addr;
      logic              d_req, d_we;
      logic [ADDR_W-1:0] d_addr;
      logic [DATA_W-1:0] d_wdata;
      logic [BE_W-1:0]   d_be;
      logic              rdy;
      logic [DATA_W-1:0] rdata;
      logic [4:0]        e_pulse;  // {f_gnt, d_gnt, f_valid, d_valid, mem_req}
      logic              e_we;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_wdata;
      logic [BE_W-1:0]   e_be;
      logic [DATA_W-1:0] e_frd, e_drd;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(
      input logic fr, input logic [31:0] fa, input logic dr, input logic dw,
      input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe,
      input logic rdy, input logic [31:0] rd, input logic [4:0] ep, input logic ew,
      input logic [31:0] ea, input logic [31:0] ewd, input logic [3:0] ebe,
      input logic [31:0] efr, input logic [31:0] edr);
      vec_t v;
      v.f_req = fr; v.f_addr = fa; v.d_req = dr; v.d_we = dw; v.d_addr = da;
      v.d_wdata = dwd; v.d_be = dbe; v.rdy = rdy; v.rdata = rd; v.e_pulse = ep;
      v.e_we = ew; v.e_addr = ea; v.e_wdata = ewd; v.e_be = ebe;
      v.e_frd = efr; v.e_drd = edr;
      return v;
   endfunction

   int nf;

   initial begin
      // Single fetch with zero-wait memory.
      vecs[0]  = mk(0, 0,     0,0, 0,     0,           0,    0, 0,            5'b00000, 0, 0,      0,           0,    0,            0);
      vecs[1]  = mk(1, 32'h4, 0,0, 0,     0,           0,    1, 32'h00500093, 5'b10001, 0, 32'h4,  0,           4'hF, 0,            0);
      vecs[2]  = mk(0, 32'h4, 0,0, 0,     0,           0,    1, 32'h00500093, 5'b00100, 0, 32'h4,  0,           4'hF, 32'h00500093, 0);
      vecs[3]  = mk(0, 0,     0,0, 0,     0,           0,    0, 32'h0BADF00D, 5'b00000, 0, 32'h4,  0,           4'hF, 32'h00500093, 0);
      // Simultaneous requests: data first, then fetch, with mem_req held.
      vecs[4]  = mk(1, 32'h10,1,0, 32'h100,0,          4'hF, 0, 32'h0BAD0001, 5'b01001, 0, 32'h100,0,           4'hF, 32'h00500093, 0);
      vecs[5]  = mk(1, 32'h10,0,0, 32'h100,0,          4'hF, 1, 32'h11112222, 5'b10011, 0, 32'h10, 0,           4'hF, 32'h00500093, 32'h11112222);
      vecs[6]  = mk(0, 0,     0,0, 0,     0,           0,    1, 32'h33334444, 5'b00100, 0, 32'h10, 0,           4'hF, 32'h33334444, 32'h11112222);
      // Write with wait states: operands stay stable and d_rdata is untouched.
      vecs[7]  = mk(0, 0,     1,1, 32'h200,32'hDEADBEEF,4'h3,0, 32'h55556666, 5'b01001, 1, 32'h200,32'hDEADBEEF,4'h3, 32'h33334444, 32'h11112222);
      vecs[8]  = mk(0, 0,     0,1, 32'h200,32'hDEADBEEF,4'h3,0, 32'h77778888, 5'b00001, 1, 32'h200,32'hDEADBEEF,4'h3, 32'h33334444, 32'h11112222);
      vecs[9]  = mk(0, 0,     0,0, 0,     0,           0,    0, 32'h9999AAAA, 5'b00001, 1, 32'h200,32'hDEADBEEF,4'h3, 32'h33334444, 32'h11112222);
      vecs[10] = mk(0, 0,     0,0, 0,     0,           0,    1, 32'hCAFEF00D, 5'b00010, 1, 32'h200,32'hDEADBEEF,4'h3, 32'h33334444, 32'h11112222);
      // mem_ready while idle is ignored.
      vecs[11] = mk(0, 0,     0,0, 0,     0,           0,    1, 32'h12345678, 5'b00000, 1, 32'h200,32'hDEADBEEF,4'h3, 32'h33334444, 32'h11112222);

      // ---- reset state ----
      do_reset();
      check("reset pulses/req/busy", {f_gnt, d_gnt, f_valid, d_valid, mem_req, busy}, 6'b0);
      check("reset state_dbg", state_dbg, 2'd0);
      check("reset mem regs", {mem_we, mem_addr, mem_wdata, mem_be}, '0);
      check("reset rdata", {f_rdata, d_rdata}, '0);

      // ---- table-driven vectors ----
      for (int i = 0; i < 12; i++) begin
         f_req = vecs[i].f_req; f_addr = vecs[i].f_addr;
         d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_addr = vecs[i].d_addr;
         d_wdata = vecs[i].d_wdata; d_be = vecs[i].d_be;
         mem_ready = vecs[i].rdy; mem_rdata = vecs[i].rdata;
         @(posedge stage_clk);
         @(negedge stage_clk);
         check($sformatf("vec%0d pulses", i), {f_gnt, d_gnt, f_valid, d_valid, mem_req}, vecs[i].e_pulse);
         check($sformatf("vec%0d busy", i), busy, vecs[i].e_pulse[0]);
         check($sformatf("vec%0d mem port", i), {mem_we, mem_addr, mem_be}, {vecs[i].e_we, vecs[i].e_addr, vecs[i].e_be});
         if (vecs[i].e_we)
            check($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
         check($sformatf("vec%0d rdata", i), {f_rdata, d_rdata}, {vecs[i].e_frd, vecs[i].e_drd});
      end

      // ---- starvation: both requests held, zero-wait memory ----
      do_reset();
      f_req = 1; f_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h300; d_be = 4'hF;
      mem_ready = 1; mem_rdata = 32'h1;
      nf = 0;
      for (int c = 0; c < 50; c++) begin
         logic exp_f;
         @(posedge stage_clk);
         @(negedge stage_clk);
         exp_f = GUARD && ((c % (STARVE_LIMIT + 1)) == STARVE_LIMIT);
         check($sformatf("starve c%0d gnts", c), {f_gnt, d_gnt}, {exp_f, !exp_f});
         nf += int'(f_gnt);
      end
      check("starve fetch grant count", nf, GUARD ? 50 / (STARVE_LIMIT + 1) : 0);

      // ---- reset during a fetch that is waiting on memory ----
      do_reset();
      f_req = 1; f_addr = 32'h20; mem_ready = 0;
      @(posedge stage_clk);
      @(negedge stage_clk);
      check("midreset gnt before", {f_gnt, mem_req, busy}, 3'b111);
      f_req = 0;
      #2 reset = 1;
      #1;
      check("midreset async clear", {f_gnt, f_valid, d_gnt, d_valid, mem_req, busy}, 6'b0);
      check("midreset state_dbg", state_dbg, 2'd0);
      @(negedge stage_clk);
      reset = 0; mem_ready = 1; mem_rdata = 32'hFFFF0000;
      @(posedge stage_clk);
      @(negedge stage_clk);
      check("midreset no valid", {f_valid, mem_req, f_rdata}, {1'b0, 1'b0, 32'h0});
      f_req = 1; f_addr = 32'h8; mem_rdata = 32'h13;
      @(posedge stage_clk);
      @(negedge stage_clk);
      check("post reset fetch gnt", {f_gnt, mem_req, mem_addr}, {1'b1, 1'b1, 32'h8});
      f_req = 0; mem_rdata = 32'h00A00113;
      @(posedge stage_clk);
      @(negedge stage_clk);
      check("post reset fetch valid", {f_valid, mem_req, f_rdata}, {1'b1, 1'b0, 32'h00A00113});

      // ---- randomized traffic against the model ----
      do_reset();
      for (int c = 0; c < 600; c++) begin
         // Requesters change a request only when idle or after seeing its grant.
         if (!f_req || m_f_gnt) begin
            f_req  = ($urandom_range(0, 99) < 50);
            f_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!d_req || m_d_gnt) begin
            d_req   = ($urandom_range(0, 99) < 55);
            d_we    = $urandom_range(0, 1) == 1;
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_be    = BE_W'($urandom_range(1, 15));
         end
         mem_ready = ($urandom_range(0, 99) < 60);
         mem_rdata = $urandom;
         @(posedge stage_clk);
         model_step();
         @(negedge stage_clk);
         check($sformatf("rand c%0d pulses", c), {f_gnt, d_gnt, f_valid, d_valid, mem_req, busy},
               {m_f_gnt, m_d_gnt, m_f_valid, m_d_valid, m_owner != 0, m_owner != 0});
         check($sformatf("rand c%0d mem port", c), {mem_we, mem_addr, mem_be}, {m_we, m_addr, m_be});
         if (m_we)
            check($sformatf("rand c%0d mem_wdata", c), mem_wdata, m_wdata);
         check($sformatf("rand c%0d rdata", c), {f_rdata, d_rdata}, {m_f_rdata, m_d_rdata});
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
